// File: rtl/adder_rr_sched_pkg.sv
// Shared constants, types and helpers for the round-robin adder scheduler.
package adder_rr_sched_pkg;

   localparam int W_DEF    = 19;
   localparam int NREQ_DEF = 4;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   localparam longint SAT_MAX = sat_max(W_DEF);
   localparam longint SAT_MIN = sat_min(W_DEF);

endpackage

// File: rtl/adder_rr_sched_rr_grant.sv
// Combinational round-robin arbiter: one-hot grant searching upward from last+1.
module rr_grant
   import adder_rr_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  last,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            any
);

   logic found;
   int   idx;

   always_comb begin
      found  = 1'b0;
      gnt_id = '0;
      idx    = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!found && valid[idx]) begin
            found  = 1'b1;
            gnt_id = IDW'(idx);
         end
      end
      any = found & en;
      gnt = '0;
      if (any) gnt[gnt_id] = 1'b1;
   end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one external adder among NREQ requesters.
// Optional build macro ADDER_RR_SCHED_SAT_EN clamps the registered sum to W-bit signed range.
//
// state    | meaning
// ST_EMPTY | output register holds nothing, res_valid=0
// ST_FULL  | output register holds a result, res_valid=1
module adder_rr_sched
   import adder_rr_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF,
   parameter int IDW  = id_width(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [W-1:0]      add_a,
   output logic [W-1:0]      add_b,
   input  logic [W:0]        add_s,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W:0]        res_sum,
   output logic [IDW-1:0]    res_id
);

   out_state_t     state_q, state_d;
   logic [IDW-1:0] last_q;
   logic [IDW-1:0] grant_id;
   logic [IDW-1:0] sel;
   logic           grant;
   logic           can_accept;
   logic [W:0]     sum_in;

   assign can_accept = (state_q == ST_EMPTY) || res_ready;
   assign res_valid  = (state_q == ST_FULL);

   rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
      .valid  (req_valid),
      .last   (last_q),
      .en     (can_accept),
      .gnt    (req_ready),
      .gnt_id (grant_id),
      .any    (grant)
   );

   // Idle cycles park the mux on the last winner so the adder sees stable, defined operands.
   assign sel   = grant ? grant_id : last_q;
   assign add_a = req_a[int'(sel)*W +: W];
   assign add_b = req_b[int'(sel)*W +: W];

`ifdef ADDER_RR_SCHED_SAT_EN
   localparam logic signed [W:0] SAT_HI = (W+1)'(sat_max(W));
   localparam logic signed [W:0] SAT_LO = (W+1)'(sat_min(W));

   always_comb begin
      sum_in = add_s;
      if ($signed(add_s) > SAT_HI)      sum_in = SAT_HI;
      else if ($signed(add_s) < SAT_LO) sum_in = SAT_LO;
   end
`else
   assign sum_in = add_s;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (grant) state_d = ST_FULL;
         ST_FULL: begin
            if (grant)          state_d = ST_FULL;
            else if (res_ready) state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         last_q  <= IDW'(NREQ - 1);
         res_sum <= '0;
         res_id  <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            last_q  <= grant_id;
            res_sum <= sum_in;
            res_id  <= grant_id;
         end
      end
   end

endmodule
